// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver.
// Frame: start + DBIT data bits (LSB first) + optional even-parity bit + stop.
// Optional feature: define UART_RX_PARITY_EN to add the PARITY state and the
// parity_err output. The default build (macro undefined) has no parity logic.
module uart_rx #(
    parameter int DBIT    = 8,   // data bits per frame, 5..8
    parameter int SB_TICK = 16   // ticks in the stop bit (16 = 1, 32 = 2 stop bits)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s_tick,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    // Data is shifted in from the MSB side, so after DBIT shifts the frame
    // sits in the top DBIT bits; this realigns it to the LSB.
    localparam int SHR = 8 - DBIT;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t     state_q, state_d;
    logic [4:0] tick_q, tick_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] data_q, data_d;
    logic       done_q, done_d;
    logic       ferr_q, ferr_d;
    logic       sync1_q, rx_s_q, rx_prev_q;
`ifdef UART_RX_PARITY_EN
    logic       par_q, par_d;
    logic       perr_q, perr_d;
`endif

    // Two-flop synchronizer plus a delayed copy for falling-edge detection.
    // All three idle high so reset never looks like a start edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= rx;
            rx_s_q    <= sync1_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // FSM, counters, shift register and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    // Next-state logic. Only the IDLE start-edge detect runs without s_tick;
    // everything else is frozen between ticks.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = perr_q;
`endif
        case (state_q)
            S_IDLE: begin
                // Edge, not level: a line stuck low cannot retrigger.
                if (rx_prev_q && !rx_s_q) begin
                    state_d = S_START;
                    tick_d  = '0;
                end
            end
            S_START: begin
                if (s_tick) begin
                    if (tick_q == 5'd7) begin
                        if (!rx_s_q) begin
                            state_d = S_DATA;
                            tick_d  = '0;
                            bit_d   = '0;
                        end else begin
                            state_d = S_IDLE;  // glitch, not a real start bit
                        end
                    end else begin
                        tick_d = tick_q + 5'd1;
                    end
                end
            end
            S_DATA: begin
                if (s_tick) begin
                    if (tick_q == 5'd15) begin
                        tick_d  = '0;
                        shreg_d = {rx_s_q, shreg_q[7:1]};
                        if (bit_q == 3'(DBIT - 1)) begin
                            bit_d   = '0;
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        tick_d = tick_q + 5'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (s_tick) begin
                    if (tick_q == 5'd15) begin
                        tick_d  = '0;
                        par_d   = rx_s_q;
                        state_d = S_STOP;
                    end else begin
                        tick_d = tick_q + 5'd1;
                    end
                end
            end
`endif
            S_STOP: begin
                if (s_tick) begin
                    if (tick_q == 5'(SB_TICK - 1)) begin
                        tick_d  = '0;
                        data_d  = shreg_q >> SHR;
                        ferr_d  = ~rx_s_q;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        perr_d  = (^(shreg_q >> SHR)) ^ par_q;
`endif
                    end else begin
                        tick_d = tick_q + 5'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rx_data   = data_q;
    assign rx_done   = done_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DBIT, default 8, data bits per frame (range 5..8).
REQ-002 SHALL have parameter SB_TICK, default 16, oversample ticks in the stop bit (16 = 1 stop bit, 32 = 2 stop bits).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port s_tick  input  1  16x baud oversample enable, one clk cycle wide per tick.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port rx_data  output  8  last received byte, LSB-aligned, unused upper bits 0.
REQ-008 SHALL have port rx_done  output  1  one-cycle pulse when a frame completes.
REQ-009 SHALL have port frame_err  output  1  stop-bit status of the last completed frame.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer; all FSM decisions use the synchronized value rx_s.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-013 SHALL keep a 5-bit tick counter and a 3-bit bit counter, advancing only on clk edges where s_tick=1.
REQ-014 IDLE: on a rx_s 1->0 transition, SHALL go to START and clear the tick counter; a line held low never restarts reception.
REQ-015 START: on tick count 7 with rx_s=0, SHALL go to DATA and clear both counters; with rx_s=1, SHALL return to IDLE (glitch reject, no rx_done).
REQ-016 DATA: on tick count 15, SHALL sample rx_s, shift it in LSB-first, clear the tick counter, and increment the bit counter; after bit DBIT-1, SHALL go to STOP (or PARITY).
REQ-017 STOP: on tick count SB_TICK-1, SHALL sample rx_s, load rx_data, set frame_err = ~rx_s, pulse rx_done on the next clk, and return to IDLE.
REQ-018 rx_data and frame_err SHALL hold their values between completions.
REQ-019 rx_done SHALL be high for exactly one clk per completed frame, including frames with errors.
REQ-020 A counter that reaches its terminal value SHALL clear to 0, never wrap past it.
REQ-021 s_tick=0 SHALL freeze the FSM and counters, except for the IDLE edge detection.

Reset
REQ-022 On reset_n=0, SHALL immediately force: state IDLE, counters 0, shift register 0, rx_data 0, rx_done 0, frame_err 0, busy 0, parity_err 0, and synchronizer flops 1.
REQ-023 A reset asserted mid-frame SHALL discard the partial frame and produce no rx_done.
REQ-024 After reset release, reception SHALL start only after a fresh 1->0 edge on rx_s.

Configuration
REQ-025 With macro UART_RX_PARITY_EN defined, SHALL add the PARITY state between DATA and STOP and an output parity_err (1 bit).
REQ-026 In PARITY, on tick count 15, SHALL sample the even-parity bit and then go to STOP.
REQ-027 parity_err SHALL update together with rx_done, set to (XOR of the data bits) XOR (parity bit).
REQ-028 Without UART_RX_PARITY_EN, the parity_err port, the PARITY state and the parity logic SHALL be absent, and the frame is start + DBIT + stop.

Verification
REQ-029 Frame 0x55, 8N1, 16 ticks/bit, valid stop -> one rx_done pulse, rx_data=0x55, frame_err=0.
REQ-030 Frame 0xA3 with stop bit driven 0 -> rx_done pulse, rx_data=0xA3, frame_err=1; no new frame until rx returns high and falls again.
REQ-031 rx low pulse lasting 4 ticks -> return to IDLE, no rx_done, busy drops after tick 7.
REQ-032 reset_n pulsed low during bit 3 of 0xFF -> outputs 0 immediately; the next full frame 0x0F -> rx_data=0x0F.
REQ-033 With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> parity_err=0; 0x07 with parity bit 0 -> parity_err=1.
REQ-034 Two back-to-back frames 0x12, 0x34 with SB_TICK=16 and no idle gap -> two rx_done pulses, with rx_data=0x12 then 0x34.
